// File: rtl/xwb.sv
// xwb: writeback stage that retires ALU results and runs 64-bit bus reads for loads into xrs.
// Latency: an ALU result is written the cycle after accept; a load is written the cycle after ack_i.
// Backpressure: ready_o is low while a load bus cycle is in flight; upstream holds valid_i.
//
// Ports: clk_i, reset_ni (asynchronous, active-low)
//   op in  : valid_i/ready_o handshake, load_i, size_i, unsigned_i, wen_i, rd_i, addr_i, result_i
//   bus    : adr_o (8-byte aligned), sel_o, cyc_o, stb_o, ack_i, dat_i
//   xrs    : rd_o, rdat_o, rwe_o (registered; rwe_o is NO outside the single write cycle)
//   fault_o: one-cycle pulse on bus timeout (or misaligned load when trapping)
// Build option: define XWB_MISALIGN_TRAP_EN to trap misaligned loads; undefined, loads are
//   forced down to the access-size boundary.
// rwe_o codes (as in xrs.vh): 0 NO, 1 S8, 2 S16, 3 S32, 4 S64, 5 U8, 6 U16, 7 U32.
module xwb #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        load_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic        wen_i,
  input  logic [4:0]  rd_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] result_i,
  output logic [63:0] adr_o,
  output logic [7:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic [63:0] dat_i,
  output logic [4:0]  rd_o,
  output logic [63:0] rdat_o,
  output logic [2:0]  rwe_o,
  output logic        fault_o
);

  localparam logic [2:0] XRS_RWE_NO  = 3'd0;
  localparam logic [2:0] XRS_RWE_S8  = 3'd1;
  localparam logic [2:0] XRS_RWE_S16 = 3'd2;
  localparam logic [2:0] XRS_RWE_S32 = 3'd3;
  localparam logic [2:0] XRS_RWE_S64 = 3'd4;
  localparam logic [2:0] XRS_RWE_U8  = 3'd5;
  localparam logic [2:0] XRS_RWE_U16 = 3'd6;
  localparam logic [2:0] XRS_RWE_U32 = 3'd7;

  typedef enum logic {IDLE, BUS} state_t;

  state_t                   state, state_nxt;
  logic                     accept;
  logic                     wr_en;
  logic                     ld_start;
  logic                     ld_trap;
  logic                     bus_done;
  logic                     timeout_hit;
  logic [2:0]               lane_mask;   // size_bytes - 1
  logic [2:0]               lane_off;    // byte offset used for sel/shift
  logic [7:0]               size_sel;
  logic [2:0]               rwe_ld;
  logic [2:0]               ld_off_q;
  logic [2:0]               ld_rwe_q;
  logic [4:0]               ld_rd_q;
  logic [TIMEOUT_WIDTH-1:0] to_cnt;

  assign ready_o  = (state == IDLE);
  assign accept   = valid_i & ready_o;
  assign wr_en    = wen_i & (rd_i != 5'd0);
  assign bus_done = (state == BUS) & ack_i;

  // Counter holds the number of completed BUS cycles without ack; abort once the
  // current one would make TIMEOUT_CYCLES. ack_i on that same edge takes priority.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == BUS) && !ack_i &&
                       (to_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    lane_mask = 3'b000;
    size_sel  = 8'h01;
    rwe_ld    = XRS_RWE_NO;
    case (size_i)
      2'd0: begin
        lane_mask = 3'b000;
        size_sel  = 8'h01;
        rwe_ld    = unsigned_i ? XRS_RWE_U8 : XRS_RWE_S8;
      end
      2'd1: begin
        lane_mask = 3'b001;
        size_sel  = 8'h03;
        rwe_ld    = unsigned_i ? XRS_RWE_U16 : XRS_RWE_S16;
      end
      2'd2: begin
        lane_mask = 3'b011;
        size_sel  = 8'h0F;
        rwe_ld    = unsigned_i ? XRS_RWE_U32 : XRS_RWE_S32;
      end
      default: begin
        lane_mask = 3'b111;
        size_sel  = 8'hFF;
        rwe_ld    = XRS_RWE_S64;
      end
    endcase
    if (!wr_en) rwe_ld = XRS_RWE_NO;
  end

`ifdef XWB_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = |(addr_i[2:0] & lane_mask);
  assign ld_start = accept & load_i & ~misalign;
  assign ld_trap  = accept & load_i & misalign;
  assign lane_off = addr_i[2:0];
`else
  assign ld_start = accept & load_i;
  assign ld_trap  = 1'b0;
  assign lane_off = addr_i[2:0] & ~lane_mask;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_start) state_nxt = BUS;
      BUS:     if (bus_done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      adr_o    <= '0;
      sel_o    <= '0;
      rd_o     <= '0;
      rdat_o   <= '0;
      rwe_o    <= XRS_RWE_NO;
      fault_o  <= 1'b0;
      to_cnt   <= '0;
      ld_off_q <= '0;
      ld_rwe_q <= XRS_RWE_NO;
      ld_rd_q  <= '0;
    end else begin
      rwe_o   <= XRS_RWE_NO;
      fault_o <= 1'b0;

      if (accept && !load_i) begin
        rd_o   <= rd_i;
        rdat_o <= result_i;
        rwe_o  <= wr_en ? XRS_RWE_S64 : XRS_RWE_NO;
      end

      if (ld_start) begin
        cyc_o    <= 1'b1;
        stb_o    <= 1'b1;
        adr_o    <= {addr_i[63:3], 3'b000};
        sel_o    <= size_sel << lane_off;
        ld_off_q <= lane_off;
        ld_rwe_q <= rwe_ld;
        ld_rd_q  <= rd_i;
        to_cnt   <= '0;
      end

      if (ld_trap) fault_o <= 1'b1;

      if (state == BUS) begin
        if (ack_i) begin
          cyc_o  <= 1'b0;
          stb_o  <= 1'b0;
          sel_o  <= '0;
          rd_o   <= ld_rd_q;
          rdat_o <= dat_i >> {ld_off_q, 3'b000};
          rwe_o  <= ld_rwe_q;
        end else if (timeout_hit) begin
          cyc_o   <= 1'b0;
          stb_o   <= 1'b0;
          sel_o   <= '0;
          fault_o <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TIMEOUT_WIDTH'(1);
        end
      end
    end
  end

endmodule
